// File: rtl/seq_div_pkg.sv
// Shared state encoding and default widths for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DVD_W = 8;
  localparam int DEF_DVS_W = 4;

endpackage

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module seq_div_step #(
  parameter int DVS_W = 4
) (
  input  logic [DVS_W-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic [DVS_W-1:0] rem_o,
  output logic             q_bit_o
);

  logic [DVS_W:0] shifted;

  // The difference is always below the divisor, so the low DVS_W bits of the modular subtract are exact.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? (shifted[DVS_W-1:0] - divisor_i) : shifted[DVS_W-1:0];
  end

endmodule

// File: rtl/seq_bin_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional SEQ_DIV_EARLY_EXIT_EN: dividend < divisor finishes in the start cycle.
module seq_bin_divider
  import seq_div_pkg::*;
#(
  parameter  int DVD_W = DEF_DVD_W,
  parameter  int DVS_W = DEF_DVS_W,
  localparam int CNT_W = $clog2(DVD_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic [CNT_W-1:0] counter
);

  state_e           state_q;
  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic             q_bit;
  logic             busy_q, done_q, dbz_q;
  logic [DVD_W-1:0] quotient_q;
  logic [DVS_W-1:0] remainder_q;
  logic [CNT_W-1:0] counter_q;

  seq_div_step #(.DVS_W(DVS_W)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[DVD_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .q_bit_o   (q_bit)
  );

  assign quo_d = (quo_q << 1) | DVD_W'(q_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      counter_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            quo_q <= '0;
            if (divisor == '0) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              dbz_q       <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= '0;
              counter_q   <= '0;
`ifdef SEQ_DIV_EARLY_EXIT_EN
            end else if (dividend < DVD_W'(divisor)) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              dbz_q       <= 1'b0;
              quotient_q  <= '0;
              remainder_q <= dividend[DVS_W-1:0];
              counter_q   <= '0;
`endif
            end else begin
              state_q   <= CALC;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              dbz_q     <= 1'b0;
              counter_q <= CNT_W'(DVD_W);
            end
          end
        end
        CALC: begin
          // Results become visible only on the final step; shift registers stay internal.
          rem_q     <= rem_d;
          quo_q     <= quo_d;
          dvd_q     <= dvd_q << 1;
          counter_q <= counter_q - CNT_W'(1);
          if (counter_q == CNT_W'(1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= quo_d;
            remainder_q <= rem_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign counter     = counter_q;

endmodule
